// File: rtl/imem_boot_loader.sv
// Byte-stream loader for the instruction memory. It receives a framed image
// (0xA5, 16-bit LE word count, LE words, XOR checksum), writes each word
// through the instruction-memory write port and releases the CPU only after
// the checksum byte matches.
//
// Byte handshake: a byte moves from the source into the loader on a rising
// clk edge where rx_valid and rx_ready are both high. rx_valid may drop at any
// time and simply stalls the loader; rx_ready is low only in WRITE.
module imem_boot_loader #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_run,
   output logic              done,
   output logic              err,
   output logic [2:0]        state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN0  = 3'd1,
      S_LEN1  = 3'd2,
      S_DATA  = 3'd3,
      S_WRITE = 3'd4,
      S_CHK   = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   localparam logic [7:0] MAGIC = 8'hA5;

   state_t              state, state_nx;
   logic [15:0]         n_words;
   logic [1:0]          byte_cnt;
   logic [16:0]         word_cnt;
   logic [7:0]          csum;
   logic [23:0]         shift;
   logic [ADDR_W-1:0]   wptr;

   logic                xfer;
   logic                is_magic;
   logic [15:0]         len_full;
   logic                oversize;
   logic                last_word;

   assign rx_ready  = (state != S_WRITE);
   assign xfer      = rx_valid && rx_ready;
   assign is_magic  = (rx_data == MAGIC);
   assign state_dbg = state;

   // Full word count as it stands while the high length byte is on rx_data.
   assign len_full  = {rx_data, n_words[7:0]};
   assign oversize  = (32'(len_full) > (32'd1 << ADDR_W));
   assign last_word = ((word_cnt + 17'd1) == {1'b0, n_words});

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state decode from the present state and the accepted byte.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (xfer && is_magic) state_nx = S_LEN0;
         S_LEN0:  if (xfer) state_nx = S_LEN1;
         S_LEN1: begin
            if (xfer) begin
               if (oversize)             state_nx = S_ERR;
               else if (len_full == '0)  state_nx = S_CHK;
               else                      state_nx = S_DATA;
            end
         end
         S_DATA:  if (xfer && byte_cnt == 2'd3) state_nx = S_WRITE;
         S_WRITE: state_nx = last_word ? S_CHK : S_DATA;
         S_CHK:   if (xfer) state_nx = (rx_data == csum) ? S_DONE : S_ERR;
         S_DONE:  if (xfer && is_magic) state_nx = S_LEN0;
         S_ERR:   if (xfer && is_magic) state_nx = S_LEN0;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath: counters, checksum, word assembly, write port and status flags.
   always_ff @(posedge clk) begin
      if (!reset) begin
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= '0;
         cpu_run  <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         n_words  <= '0;
         byte_cnt <= '0;
         word_cnt <= '0;
         csum     <= '0;
         shift    <= '0;
         wptr     <= '0;
      end else begin
         im_we <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERR: begin
               if (xfer && is_magic) begin
                  csum     <= '0;
                  wptr     <= ADDR_W'(BASE_ADDR);
                  word_cnt <= '0;
                  byte_cnt <= '0;
                  cpu_run  <= 1'b0;
                  done     <= 1'b0;
                  err      <= 1'b0;
               end
            end
            S_LEN0: begin
               if (xfer) begin
                  n_words[7:0] <= rx_data;
                  csum         <= csum ^ rx_data;
               end
            end
            S_LEN1: begin
               if (xfer) begin
                  n_words[15:8] <= rx_data;
                  csum          <= csum ^ rx_data;
                  if (oversize) err <= 1'b1;
               end
            end
            S_DATA: begin
               if (xfer) begin
                  csum     <= csum ^ rx_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  shift    <= {rx_data, shift[23:8]};
                  // 4th byte: the word is complete, present it next cycle.
                  if (byte_cnt == 2'd3) begin
                     im_we    <= 1'b1;
                     im_addr  <= wptr;
                     im_wdata <= {rx_data, shift};
                  end
               end
            end
            S_WRITE: begin
               word_cnt <= word_cnt + 17'd1;
               wptr     <= wptr + 1'b1;
            end
            S_CHK: begin
               if (xfer) begin
                  if (rx_data == csum) begin
                     done    <= 1'b1;
                     cpu_run <= 1'b1;
                     err     <= 1'b0;
                  end else begin
                     err     <= 1'b1;
                     done    <= 1'b0;
                     cpu_run <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (BASE_ADDR 0 and 0xFF) share the
// byte bus; sel picks which one sees rx_valid.
module tb_imem_boot_loader;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LEN0  = 3'd1;
   localparam logic [2:0] ST_LEN1  = 3'd2;
   localparam logic [2:0] ST_DATA  = 3'd3;
   localparam logic [2:0] ST_WRITE = 3'd4;
   localparam logic [2:0] ST_CHK   = 3'd5;
   localparam logic [2:0] ST_DONE  = 3'd6;
   localparam logic [2:0] ST_ERR   = 3'd7;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       sel = 1'b0;

   logic       rx_valid0, rx_valid1;
   logic       rdy0, rdy1, we0, we1, run0, run1, done0, done1, err0, err1;
   logic [7:0] addr0, addr1;
   logic [31:0] data0, data1;
   logic [2:0] state0, state1;
   logic       rdy;

   assign rx_valid0 = rx_valid && !sel;
   assign rx_valid1 = rx_valid && sel;
   assign rdy       = sel ? rdy1 : rdy0;

   imem_boot_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut0 (
      .clk(clk), .reset(reset), .rx_valid(rx_valid0), .rx_data(rx_data),
      .rx_ready(rdy0), .im_we(we0), .im_addr(addr0), .im_wdata(data0),
      .cpu_run(run0), .done(done0), .err(err0), .state_dbg(state0));

   imem_boot_loader #(.ADDR_W(8), .BASE_ADDR(8'hFF)) dut1 (
      .clk(clk), .reset(reset), .rx_valid(rx_valid1), .rx_data(rx_data),
      .rx_ready(rdy1), .im_we(we1), .im_addr(addr1), .im_wdata(data1),
      .cpu_run(run1), .done(done1), .err(err1), .state_dbg(state1));

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [40:0] exp_q[$];   // {dut tag, addr, data}

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_write(input logic tag, input logic [7:0] a, input logic [31:0] d);
      exp_q.push_back({tag, a, d});
   endtask

   task automatic check_write(input logic tag, input logic [7:0] a, input logic [31:0] d);
      logic [40:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_write: got dut%0d addr %0h data %0h, none expected", tag, a, d);
      end else begin
         e = exp_q.pop_front();
         if (e !== {tag, a, d}) begin
            errors++;
            $display("FAIL write: got dut%0d addr %0h data %0h expected dut%0d addr %0h data %0h",
                     tag, a, d, e[40], e[39:32], e[31:0]);
         end
      end
   endtask

   // Monitor: every im_we pulse must match the head of the expected queue.
   always @(negedge clk) begin
      if (we0) check_write(1'b0, addr0, data0);
      if (we1) check_write(1'b1, addr1, data1);
   end

   // ---------------- driver tasks ----------------
   // Called just after a rising edge; returns just after the transfer edge.
   task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
      bit got;
      if (gap > 0) begin
         rx_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      rx_valid = 1'b1;
      rx_data  = b;
      waited   = 0;
      got      = 1'b0;
      while (!got && waited < 20) begin
         @(negedge clk);
         if (rdy) begin
            @(posedge clk);
            #1;
            got = 1'b1;
         end else begin
            @(posedge clk);
            #1;
            waited++;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL rx_timeout: byte %0h not accepted within 20 cycles", b);
      end
   endtask

   task automatic sb(input logic [7:0] b);
      int w;
      send_byte(b, 0, w);
   endtask

   task automatic sb_gap(input logic [7:0] b);
      int w;
      send_byte(b, $urandom_range(0, 3), w);
   endtask

   task automatic idle(input int n);
      rx_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_flags(input string name, input logic d, input logic r, input logic e);
      chk({name, "_done"}, {31'd0, done0}, {31'd0, d});
      chk({name, "_cpu_run"}, {31'd0, run0}, {31'd0, r});
      chk({name, "_err"}, {31'd0, err0}, {31'd0, e});
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] b;
      int         exp_wait;
      logic [2:0] exp_state;
   } vec_t;

   vec_t tbl[12];

   task automatic send_nominal();
      expect_write(1'b0, 8'h00, 32'h44332211);
      expect_write(1'b0, 8'h01, 32'h88776655);
      for (int i = 0; i < 12; i++) sb(tbl[i].b);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // ---------------- test sequence ----------------
   initial begin
      int w;
      tbl[0]  = '{8'hA5, 0, ST_LEN0};
      tbl[1]  = '{8'h02, 0, ST_LEN1};
      tbl[2]  = '{8'h00, 0, ST_DATA};
      tbl[3]  = '{8'h11, 0, ST_DATA};
      tbl[4]  = '{8'h22, 0, ST_DATA};
      tbl[5]  = '{8'h33, 0, ST_DATA};
      tbl[6]  = '{8'h44, 0, ST_WRITE};
      tbl[7]  = '{8'h55, 1, ST_DATA};
      tbl[8]  = '{8'h66, 0, ST_DATA};
      tbl[9]  = '{8'h77, 0, ST_DATA};
      tbl[10] = '{8'h88, 0, ST_WRITE};
      tbl[11] = '{8'h8A, 1, ST_DONE};

      // Reset state
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_state", {29'd0, state0}, {29'd0, ST_IDLE});
      chk("rst_rx_ready", {31'd0, rdy0}, 32'd1);
      chk("rst_im_we", {31'd0, we0}, 32'd0);
      check_flags("rst", 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 1: nominal load, valid held high, table-driven
      expect_write(1'b0, 8'h00, 32'h44332211);
      expect_write(1'b0, 8'h01, 32'h88776655);
      for (int i = 0; i < 12; i++) begin
         send_byte(tbl[i].b, 0, w);
         chk($sformatf("t1_wait[%0d]", i), w, tbl[i].exp_wait);
         chk($sformatf("t1_state[%0d]", i), {29'd0, state0}, {29'd0, tbl[i].exp_state});
      end
      idle(1);
      check_flags("t1", 1'b1, 1'b1, 1'b0);
      chk("t1_writes_left", exp_q.size(), 0);

      // 2: bad checksum, then a good frame
      expect_write(1'b0, 8'h00, 32'h44332211);
      expect_write(1'b0, 8'h01, 32'h88776655);
      for (int i = 0; i < 11; i++) sb(tbl[i].b);
      sb(8'h8B);
      idle(1);
      chk("t2_state", {29'd0, state0}, {29'd0, ST_ERR});
      check_flags("t2_bad", 1'b0, 1'b0, 1'b1);
      chk("t2_writes_left", exp_q.size(), 0);
      send_nominal();
      idle(1);
      check_flags("t2_good", 1'b1, 1'b1, 1'b0);

      // 3: zero length
      sb(8'hA5);
      check_flags("t3_restart", 1'b0, 1'b0, 1'b0);
      sb(8'h00);
      sb(8'h00);
      chk("t3_state_chk", {29'd0, state0}, {29'd0, ST_CHK});
      sb(8'h00);
      idle(1);
      chk("t3_state", {29'd0, state0}, {29'd0, ST_DONE});
      check_flags("t3", 1'b1, 1'b1, 1'b0);

      // 4: oversize count 257 with ADDR_W=8
      sb(8'hA5);
      sb(8'h01);
      sb(8'h01);
      chk("t4_state", {29'd0, state0}, {29'd0, ST_ERR});
      check_flags("t4", 1'b0, 1'b0, 1'b1);
      sb(8'h00);
      sb(8'h11);
      sb(8'h5A);
      idle(1);
      chk("t4_state_hold", {29'd0, state0}, {29'd0, ST_ERR});
      chk("t4_err_hold", {31'd0, err0}, 32'd1);

      // 5: reset mid-frame, then a frame with random stalls
      sb(8'hA5);
      sb(8'h02);
      sb(8'h00);
      sb(8'h11);
      sb(8'h22);
      rx_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_state", {29'd0, state0}, {29'd0, ST_IDLE});
      chk("t5_im_addr", {24'd0, addr0}, 32'd0);
      chk("t5_im_wdata", data0, 32'd0);
      chk("t5_im_we", {31'd0, we0}, 32'd0);
      check_flags("t5_rst", 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      expect_write(1'b0, 8'h00, 32'hEFBEADDE);
      sb_gap(8'hA5);
      sb_gap(8'h01);
      sb_gap(8'h00);
      sb_gap(8'hDE);
      sb_gap(8'hAD);
      sb_gap(8'hBE);
      sb_gap(8'hEF);
      sb_gap(8'h23);
      idle(1);
      check_flags("t5", 1'b1, 1'b1, 1'b0);
      chk("t5_writes_left", exp_q.size(), 0);

      // 6: garbage dropped, reload from DONE, address wrap on BASE_ADDR=0xFF
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      sb(8'h00);
      sb(8'hFF);
      sb(8'h5A);
      chk("t6_garbage_state", {29'd0, state0}, {29'd0, ST_IDLE});
      sb(8'hA5);
      sb(8'h00);
      sb(8'h00);
      sb(8'h00);
      idle(1);
      check_flags("t6_first", 1'b1, 1'b1, 1'b0);
      sb(8'hA5);
      chk("t6_reload_state", {29'd0, state0}, {29'd0, ST_LEN0});
      check_flags("t6_reload", 1'b0, 1'b0, 1'b0);
      sb(8'h00);
      sb(8'h00);
      sb(8'h00);
      idle(1);
      check_flags("t6_reload_done", 1'b1, 1'b1, 1'b0);

      sel = 1'b1;
      expect_write(1'b1, 8'hFF, 32'h04030201);
      expect_write(1'b1, 8'h00, 32'h08070605);
      sb(8'hA5);
      sb(8'h02);
      sb(8'h00);
      for (int i = 1; i <= 8; i++) sb(8'(i));
      sb(8'h0A);
      idle(1);
      chk("t6_wrap_state", {29'd0, state1}, {29'd0, ST_DONE});
      chk("t6_wrap_done", {31'd0, done1}, 32'd1);
      chk("t6_wrap_cpu_run", {31'd0, run1}, 32'd1);
      chk("t6_writes_left", exp_q.size(), 0);
      sel = 1'b0;

      idle(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
